// File: rtl/siteswap_scheduler.sv
// siteswap_scheduler: turns a latched siteswap pattern into a per-beat stream of throws.
// Latency: a throw appears on the outputs one cycle after the new_beat pulse that caused it.
// Backpressure: none; every new_beat in RUN is consumed, and any landing conflict parks the block in ERROR.
//
// Ports:
//   clk_in, rst_in       clock and synchronous active-high reset
//   new_beat             one-cycle pulse per juggling beat
//   pattern_in[6:0]      throw heights (entry 0 first), pattern_length used entries,
//   num_balls_in         ball count, all qualified by the level pattern_valid_in
//   throw_*_out          registered throw: one-cycle valid plus held ball/height/hand (0=right)
//   error_out, running_out, balls_launched_out   status
// Build option: SCHED_ERR_RECOVER_EN lets a pattern_valid_in rising edge leave ERROR;
// without it only rst_in leaves ERROR.
module siteswap_scheduler #(
  parameter int MAX_BALLS = 7
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       new_beat,
  input  logic [2:0] pattern_in [6:0],
  input  logic [2:0] pattern_length,
  input  logic [2:0] num_balls_in,
  input  logic       pattern_valid_in,
  output logic       throw_valid_out,
  output logic [2:0] throw_ball_out,
  output logic [2:0] throw_height_out,
  output logic       throw_hand_out,
  output logic       error_out,
  output logic       running_out,
  output logic [2:0] balls_launched_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ERROR = 2'd2} state_e;

  localparam logic [2:0] MAXB = 3'(MAX_BALLS);

  state_e           state_q, state_d;
  logic             pv_q;
  logic [2:0]       pat_q [6:0];
  logic [2:0]       len_q, nb_q;
  logic [2:0]       ptr_q, idx_q, launch_q;
  logic [7:0]       occ_q;
  logic [7:0][2:0]  id_q;
  logic             tv_q, hand_q;
  logic [2:0]       ball_q, height_q;

  logic             rise, fall, capture, beat_go;
  logic [2:0]       h, tgt, cap, beat_ball;
  logic             beat_err, beat_throw, use_new;

  assign rise = pattern_valid_in & ~pv_q;
  assign fall = ~pattern_valid_in & pv_q;

`ifdef SCHED_ERR_RECOVER_EN
  assign capture = rise;
`else
  assign capture = rise && (state_q != ERROR);
`endif

  // Capture and a falling valid both take precedence over a beat in the same cycle.
  assign beat_go = new_beat && (state_q == RUN) && !capture && !fall;

  // Effective ball limit: the smaller of the generator's count and the build cap.
  assign cap = (nb_q < MAXB) ? nb_q : MAXB;

  // Evaluate the current beat against the landing table.
  always_comb begin
    h          = pat_q[idx_q];
    tgt        = ptr_q + h;
    beat_ball  = launch_q;
    beat_err   = 1'b0;
    beat_throw = 1'b0;
    use_new    = 1'b0;
    if (h == 3'd0) begin
      // A ball landing on a zero-throw beat has nowhere to go.
      beat_err = occ_q[ptr_q];
    end else begin
      if (occ_q[ptr_q]) begin
        beat_ball = id_q[ptr_q];
      end else if (launch_q == cap) begin
        beat_err = 1'b1;
      end else begin
        use_new = 1'b1;
      end
      // h is at most 7, so tgt never aliases the slot being emptied.
      if (occ_q[tgt]) beat_err = 1'b1;
      beat_throw = !beat_err;
    end
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (capture) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (fall)                     state_d = IDLE;
      else if (beat_go && beat_err) state_d = ERROR;
    end
  end

  // State-decoded outputs
  always_comb begin
    running_out = (state_q == RUN);
    error_out   = (state_q == ERROR);
  end

  // Datapath: pattern latch, landing table, counters and registered throw.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pv_q     <= 1'b0;
      len_q    <= '0;
      nb_q     <= '0;
      ptr_q    <= '0;
      idx_q    <= '0;
      launch_q <= '0;
      occ_q    <= '0;
      id_q     <= '0;
      tv_q     <= 1'b0;
      ball_q   <= '0;
      height_q <= '0;
      hand_q   <= 1'b0;
      for (int i = 0; i < 7; i++) pat_q[i] <= '0;
    end else begin
      pv_q <= pattern_valid_in;
      tv_q <= 1'b0;
      if (capture) begin
        pat_q    <= pattern_in;
        len_q    <= pattern_length;
        nb_q     <= num_balls_in;
        occ_q    <= '0;
        ptr_q    <= '0;
        idx_q    <= '0;
        launch_q <= '0;
      end else if ((state_q == RUN) && fall) begin
        occ_q <= '0;
      end else if (beat_go && !beat_err) begin
        ptr_q <= ptr_q + 3'd1;
        idx_q <= (idx_q == len_q - 3'd1) ? 3'd0 : idx_q + 3'd1;
        if (beat_throw) begin
          occ_q[ptr_q] <= 1'b0;
          occ_q[tgt]   <= 1'b1;
          id_q[tgt]    <= beat_ball;
          if (use_new) launch_q <= launch_q + 3'd1;
          tv_q     <= 1'b1;
          ball_q   <= beat_ball;
          height_q <= h;
          hand_q   <= ptr_q[0];
        end
      end
    end
  end

  assign throw_valid_out    = tv_q;
  assign throw_ball_out     = ball_q;
  assign throw_height_out   = height_q;
  assign throw_hand_out     = hand_q;
  assign balls_launched_out = launch_q;

endmodule

// File: tb/tb_siteswap_scheduler.sv
// tb_siteswap_scheduler: directed checks of the siteswap scheduler.
// Latency: inputs driven and outputs sampled 1 ns after each rising edge.
// Backpressure: not applicable; the bench owns all inputs.
module tb_siteswap_scheduler;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       new_beat;
  logic [2:0] pattern_in [6:0];
  logic [2:0] pattern_length;
  logic [2:0] num_balls_in;
  logic       pattern_valid_in;
  logic       throw_valid_out;
  logic [2:0] throw_ball_out;
  logic [2:0] throw_height_out;
  logic       throw_hand_out;
  logic       error_out;
  logic       running_out;
  logic [2:0] balls_launched_out;

  int n_chk  = 0;
  int n_pass = 0;

  siteswap_scheduler #(.MAX_BALLS(7)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .new_beat           (new_beat),
    .pattern_in         (pattern_in),
    .pattern_length     (pattern_length),
    .num_balls_in       (num_balls_in),
    .pattern_valid_in   (pattern_valid_in),
    .throw_valid_out    (throw_valid_out),
    .throw_ball_out     (throw_ball_out),
    .throw_height_out   (throw_height_out),
    .throw_hand_out     (throw_hand_out),
    .error_out          (error_out),
    .running_out        (running_out),
    .balls_launched_out (balls_launched_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic stop_pattern();
    pattern_valid_in = 1'b0;
    tick();
  endtask

  task automatic start_pattern(input logic [2:0] p0, input logic [2:0] p1, input logic [2:0] p2,
                               input logic [2:0] len, input logic [2:0] nb, input logic with_beat);
    for (int i = 0; i < 7; i++) pattern_in[i] = 3'd0;
    pattern_in[0]    = p0;
    pattern_in[1]    = p1;
    pattern_in[2]    = p2;
    pattern_length   = len;
    num_balls_in     = nb;
    pattern_valid_in = 1'b1;
    new_beat         = with_beat;
    tick();
    new_beat = 1'b0;
  endtask

  // One beat: check the throw seen the cycle after, then check the pulse has dropped.
  task automatic beat_expect(input string tag, input logic ev, input logic [2:0] eb,
                             input logic [2:0] eh, input logic ehand);
    new_beat = 1'b1;
    tick();
    new_beat = 1'b0;
    chk({tag, ".valid"}, throw_valid_out, ev);
    if (ev) begin
      chk({tag, ".ball"},   throw_ball_out,   eb);
      chk({tag, ".height"}, throw_height_out, eh);
      chk({tag, ".hand"},   throw_hand_out,   ehand);
    end
    tick();
    chk({tag, ".pulse"}, throw_valid_out, 1'b0);
  endtask

  int b26 [7] = '{0, 1, 2, 0, 1, 2, 0};
  int b27 [7] = '{0, 1, 1, 2, 2, 0, 0};
  int h27 [7] = '{5, 1, 5, 1, 5, 1, 5};
  int v28 [6] = '{1, 1, 0, 1, 1, 0};
  int b28 [6] = '{0, 1, 0, 0, 1, 0};

  initial begin
    rst_in = 1'b1;
    new_beat = 1'b0;
    pattern_valid_in = 1'b0;
    pattern_length = 3'd0;
    num_balls_in = 3'd0;
    for (int i = 0; i < 7; i++) pattern_in[i] = 3'd0;
    tick();
    tick();
    rst_in = 1'b0;
    chk("rst.valid",   throw_valid_out, 1'b0);
    chk("rst.running", running_out, 1'b0);
    chk("rst.error",   error_out, 1'b0);
    chk("rst.ball",    throw_ball_out, 3'd0);
    chk("rst.launch",  balls_launched_out, 3'd0);
    beat_expect("idle", 1'b0, 3'd0, 3'd0, 1'b0);

    // Cascade 3, three balls
    start_pattern(3'd3, 3'd0, 3'd0, 3'd1, 3'd3, 1'b0);
    chk("p3.running", running_out, 1'b1);
    for (int i = 0; i < 7; i++)
      beat_expect($sformatf("p3.b%0d", i), 1'b1, 3'(b26[i]), 3'd3, 1'(i & 1));
    chk("p3.error",  error_out, 1'b0);
    chk("p3.launch", balls_launched_out, 3'd3);

    // 51: the capture cycle also carries a beat, which must be ignored
    stop_pattern();
    start_pattern(3'd5, 3'd1, 3'd0, 3'd2, 3'd3, 1'b1);
    chk("p51.capbeat", throw_valid_out, 1'b0);
    chk("p51.launch0", balls_launched_out, 3'd0);
    for (int i = 0; i < 7; i++)
      beat_expect($sformatf("p51.b%0d", i), 1'b1, 3'(b27[i]), 3'(h27[i]), 1'(i & 1));
    chk("p51.error", error_out, 1'b0);

    // 330: gaps on zero-height beats
    stop_pattern();
    start_pattern(3'd3, 3'd3, 3'd0, 3'd3, 3'd2, 1'b0);
    for (int i = 0; i < 6; i++)
      beat_expect($sformatf("p330.b%0d", i), 1'(v28[i]), 3'(b28[i]), 3'd3, 1'(i & 1));
    chk("p330.error", error_out, 1'b0);

    // 3 with only two balls: third beat needs a ball that does not exist
    stop_pattern();
    start_pattern(3'd3, 3'd0, 3'd0, 3'd1, 3'd2, 1'b0);
    beat_expect("err.b0", 1'b1, 3'd0, 3'd3, 1'b0);
    beat_expect("err.b1", 1'b1, 3'd1, 3'd3, 1'b1);
    beat_expect("err.b2", 1'b0, 3'd0, 3'd0, 1'b0);
    chk("err.error",   error_out, 1'b1);
    chk("err.running", running_out, 1'b0);
    beat_expect("err.b3", 1'b0, 3'd0, 3'd0, 1'b0);
    chk("err.sticky", error_out, 1'b1);

    // New pattern edge while in ERROR
    stop_pattern();
    start_pattern(3'd3, 3'd0, 3'd0, 3'd1, 3'd3, 1'b0);
`ifdef SCHED_ERR_RECOVER_EN
    chk("rec.error",   error_out, 1'b0);
    chk("rec.running", running_out, 1'b1);
    beat_expect("rec.b0", 1'b1, 3'd0, 3'd3, 1'b0);
    beat_expect("rec.b1", 1'b1, 3'd1, 3'd3, 1'b1);
`else
    chk("rec.error",   error_out, 1'b1);
    chk("rec.running", running_out, 1'b0);
    beat_expect("rec.b0", 1'b0, 3'd0, 3'd0, 1'b0);
`endif
    rst_in = 1'b1;
    pattern_valid_in = 1'b0;
    tick();
    rst_in = 1'b0;
    chk("rec.rst_error", error_out, 1'b0);

    // Drop valid mid-run
    start_pattern(3'd3, 3'd0, 3'd0, 3'd1, 3'd3, 1'b0);
    beat_expect("drop.b0", 1'b1, 3'd0, 3'd3, 1'b0);
    beat_expect("drop.b1", 1'b1, 3'd1, 3'd3, 1'b1);
    stop_pattern();
    chk("drop.running", running_out, 1'b0);
    beat_expect("drop.b2", 1'b0, 3'd0, 3'd0, 1'b0);

    // Reset mid-run, with pattern_valid still high during the reset cycle
    start_pattern(3'd3, 3'd0, 3'd0, 3'd1, 3'd3, 1'b0);
    beat_expect("rstrun.b0", 1'b1, 3'd0, 3'd3, 1'b0);
    new_beat = 1'b1;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    new_beat = 1'b0;
    pattern_valid_in = 1'b0;
    chk("rstrun.running", running_out, 1'b0);
    chk("rstrun.valid",   throw_valid_out, 1'b0);
    chk("rstrun.ball",    throw_ball_out, 3'd0);
    chk("rstrun.height",  throw_height_out, 3'd0);
    chk("rstrun.hand",    throw_hand_out, 1'b0);
    chk("rstrun.launch",  balls_launched_out, 3'd0);
    chk("rstrun.error",   error_out, 1'b0);
    beat_expect("rstrun.b1", 1'b0, 3'd0, 3'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/siteswap_scheduler.md
SITESWAP_SCHEDULER -- requirements
Module: siteswap_scheduler

Interface
REQ-001 SHALL have parameter MAX_BALLS, default 7, the highest ball id + 1 the scheduler can introduce (1..7).
REQ-002 SHALL have port clk_in, input, 1 bit: the single clock; all logic on posedge.
REQ-003 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port new_beat, input, 1 bit: one-cycle pulse per juggling beat.
REQ-005 SHALL have port pattern_in, input, 7 x 3 bits unpacked [6:0]: throw heights, entry 0 thrown first.
REQ-006 SHALL have port pattern_length, input, 3 bits: number of used entries (1..7).
REQ-007 SHALL have port num_balls_in, input, 3 bits: ball count from pattern generator.
REQ-008 SHALL have port pattern_valid_in, input, 1 bit: level, high while pattern/length/ball count are valid.
REQ-009 SHALL have outputs throw_valid_out (1), throw_ball_out (3), throw_height_out (3), throw_hand_out (1, 0=right), error_out (1), running_out (1), balls_launched_out (3).

Function
REQ-010 SHALL implement states IDLE, RUN, ERROR; running_out high only in RUN.
REQ-011 SHALL, on a rising edge of pattern_valid_in (registered previous value), latch pattern_in, pattern_length, num_balls_in, clear all slots, zero beat pointer, pattern index and launch count, enter RUN.
REQ-012 SHALL give capture priority over a new_beat in the same cycle; that beat is ignored.
REQ-013 SHALL, on a falling edge of pattern_valid_in in RUN, return to IDLE and clear slots next cycle.
REQ-014 SHALL keep an 8-entry circular landing table indexed by a 3-bit beat pointer; each entry: occupied bit + 3-bit ball id.
REQ-015 SHALL, on new_beat in RUN with h = latched pattern[index] and slot S = table[pointer]: if h=0 and S empty, emit no throw; if h=0 and S occupied, go ERROR.
REQ-016 SHALL, for h>0: use S's ball if occupied; else introduce ball id = launch count and increment it; if launch count == min(num_balls, MAX_BALLS), go ERROR instead.
REQ-017 SHALL write ball to table[(pointer + h) mod 8]; if that slot (other than S itself when h=8-wrap is impossible) is occupied, go ERROR; clear S.
REQ-018 SHALL increment pointer mod 8 every RUN beat and pattern index wrapping from pattern_length-1 to 0.
REQ-019 SHALL register throw outputs: throw_valid_out high exactly one cycle, the cycle after new_beat; ball/height/hand hold until next throw.
REQ-020 SHALL set throw_hand_out = beat-pointer parity at the throw (even = right).
REQ-021 SHALL, in ERROR, set error_out high, emit no throws, ignore new_beat.
REQ-022 SHALL ignore new_beat in IDLE.

Reset
REQ-023 SHALL on rst_in: state IDLE, table cleared, pointer/index/launch count 0, all outputs 0, previous-valid register 0.
REQ-024 SHALL let reset override every other event in the same cycle, including mid-RUN and ERROR.

Configuration
REQ-025 SHALL honour macro SCHED_ERR_RECOVER_EN: defined, ERROR exits on a pattern_valid_in rising edge per REQ-011 (error_out cleared); undefined, ERROR exits only via rst_in.

Verification
REQ-026 Pattern {3}, len 1, 3 balls, 7 beats -> balls 0,1,2,0,1,2,0, height 3, hands R,L,R,L,..., error_out 0.
REQ-027 Pattern {5,1}, len 2, 3 balls, 7 beats -> (ball,height) (0,5),(1,1),(1,5),(2,1),(2,5),(0,1),(0,5).
REQ-028 Pattern {3,3,0}, len 3, 2 balls, 6 beats -> throws on beats 0,1,3,4 with balls 0,1,0,1; no throw_valid_out on beats 2,5.
REQ-029 Pattern {3}, len 1, num_balls_in 2 -> beats 0,1 throw balls 0,1; beat 2 -> error_out 1, no pulse; later beats silent.
REQ-030 Drop pattern_valid_in mid-RUN, and separately assert rst_in mid-RUN -> running_out 0 next cycle, no further throws, outputs per REQ-023 after reset.
REQ-031 Error then new pattern_valid_in rising edge -> with SCHED_ERR_RECOVER_EN RUN resumes from ball 0; without, error_out stays 1 until rst_in.
